mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter sharing the single core memory bus between the instruction prefetch path and the load/store data path. Sits between the fetch stage (`imem_*`) and the data access stage (`dmem_*`) on one side and the unified memory interface (`mem_*`) on the other. Data requests have priority. A starvation counter forces an instruction grant after a bounded run of data grants. One transaction is outstanding at a time.

## Interface
- `starve_limit`, default 4: consecutive data grants allowed while an instruction request waits (≥1).
- `rst` in 1: reset, asynchronous, active-high.
- `clk` in 1: clock, rising edge.
- `imem_valid` in 1: instruction request; held high with `imem_addr` stable until `imem_ready`.
- `imem_addr` in 32: fetch address; bits [1:0] are forced to 0 on the bus.
- `imem_rdata` out 32: fetch data; valid only when `imem_ready`=1.
- `imem_ready` out 1: one-cycle completion strobe for instruction request.
- `dmem_valid` in 1: data request; held high with fields stable until `dmem_ready`.
- `dmem_addr` in 32: data address.
- `dmem_wdata` in 32: store data.
- `dmem_wstrb` in 4: byte strobes; 0 = load.
- `dmem_rdata` out 32: load data; valid only when `dmem_ready`=1.
- `dmem_ready` out 1: one-cycle completion strobe for data request.
- `mem_valid` out 1: bus request; held until `mem_ready`.
- `mem_instr` out 1: 1 = instruction fetch.
- `mem_addr` out 32: bus address.
- `mem_wdata` out 32: bus write data.
- `mem_wstrb` out 4: bus byte strobes.
- `mem_rdata` in 32: bus read data; valid with `mem_ready`.
- `mem_ready` in 1: bus completion strobe.

## Operation
- FSM states: IDLE, GNT_I, GNT_D, DONE.
- **IDLE.** If either valid is high, grant per priority and latch the winner's fields into bus registers. Next state is GNT_I or GNT_D.
- **Priority.** Grant D if `dmem_valid` and not starving. Grant I if `imem_valid` and (`dmem_valid`=0 or starving).
  - starving = `imem_valid`=1 and `scnt`==`starve_limit`.
- **Starvation counter `scnt`.** Width clog2(`starve_limit`+1). Evaluated at each IDLE grant:
  - D grant with `imem_valid`=1: increment, saturating at `starve_limit`.
  - D grant with `imem_valid`=0: clear to 0.
  - Any I grant: clear to 0.
- **GNT_I / GNT_D.**
  - `mem_valid`=1 with latched fields.
  - I grant drives `mem_instr`=1, `mem_wstrb`=0, `mem_wdata`=0, `mem_addr`={addr[31:2],2'b00}.
  - On `mem_ready`=1: the granted port's ready=1 and rdata=`mem_rdata` in the same cycle (combinational). Next state is DONE.
- **DONE.** One bubble cycle so the requester can drop or change valid. All outputs are inactive. Next state is IDLE.
- Non-granted port: ready=0 and rdata=0 at all times.
- `mem_ready` in IDLE or DONE is ignored.
- Requester fields changing while granted have no effect, because the bus uses latched copies.

## Timing
- **Reset values.** On `rst`=1 all outputs go to 0 immediately (asynchronous). State = IDLE, `scnt`=0, bus registers = 0.
- **Reset mid-transaction.** The transaction is abandoned with no ready strobe. The memory is reset in the same domain.
- **Latency.**
  - Valid seen in IDLE at cycle N gives `mem_valid`=1 from N+1.
  - Port ready in the cycle `mem_ready` arrives (cycle M ≥ N+1).
  - DONE at M+1, IDLE at M+2.
  - Next grant is registered at M+2 and visible on the bus at M+3.
  - Minimum transaction spacing: 3 cycles for a zero-wait-state memory.
- **Simultaneous requests.** D wins unless starving. The losing valid stays high and is re-arbitrated in the next IDLE.
- With `starve_limit`=4 and both ports continuously valid, the grant pattern is D,D,D,D,I repeating.

## Test plan
- **Reset.** Assert `rst` mid-GNT_D with `mem_ready`=0 → all outputs 0 within the same cycle. After release with no valids, FSM stays in IDLE and `mem_valid`=0.
- **Single fetch.** `imem_valid`=1, `imem_addr`=0x0000_1006, `mem_ready` at the 3rd bus cycle with `mem_rdata`=0xDEAD_BEEF:
  - bus shows `mem_addr`=0x0000_1004, `mem_instr`=1, `mem_wstrb`=0;
  - `imem_ready`=1 and `imem_rdata`=0xDEAD_BEEF in exactly that cycle;
  - `dmem_ready` stays 0.
- **Store.** `dmem_wstrb`=4'b0011, `dmem_wdata`=0x1234_5678, `dmem_addr`=0x2000, zero-wait memory:
  - bus matches exactly with `mem_instr`=0;
  - `dmem_ready` at cycle N+1;
  - the next grant appears no earlier than N+3.
- **Collision.** Both valid in the same IDLE cycle with `scnt`=0 → D granted first, I granted in the following IDLE.
- **Starvation.** `starve_limit`=4, both valids held continuously for 10 transactions → grant order D,D,D,D,I,D,D,D,D,I. `scnt` returns to 0 after each I grant.
- **Stability.** Change `dmem_addr` and `dmem_wdata` while GNT_D waits 5 cycles for `mem_ready` → `mem_addr` and `mem_wdata` keep the latched values. A spurious `mem_ready` pulse in IDLE produces no ready strobe.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and unified memory bus signals of the arbiter
interface mem_arbiter_if;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        dmem_valid;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  modport slave (
    input  imem_valid, imem_addr, dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb, mem_rdata, mem_ready,
    output imem_rdata, imem_ready, dmem_rdata, dmem_ready, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
  );
  modport master (
    output imem_valid, imem_addr, dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb, mem_rdata, mem_ready,
    input  imem_rdata, imem_ready, dmem_rdata, dmem_ready, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: data-priority arbiter of fetch and load/store onto one memory bus with starvation guard
module mem_arbiter #(
  parameter int starve_limit = 4
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int sw = $clog2(starve_limit + 1);
  localparam logic [1:0] idle = 2'd0, gnt_i = 2'd1, gnt_d = 2'd2, done = 2'd3;
  logic [1:0]    state_q, state_d;
  logic [sw-1:0] scnt_q, scnt_d;
  logic          instr_q, instr_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          starving, win_d, win_i, load, busy;
  always_comb begin
    starving = bus.imem_valid && scnt_q == sw'(starve_limit);
    win_d    = bus.dmem_valid && !starving;
    win_i    = bus.imem_valid && (!bus.dmem_valid || starving);
    load     = state_q == idle && (win_d || win_i);
    busy     = state_q == gnt_i || state_q == gnt_d;
    state_d  = state_q == idle ? (win_d ? gnt_d : win_i ? gnt_i : idle) :
               busy ? (bus.mem_ready ? done : state_q) : idle;
    scnt_d   = !load ? scnt_q :
               (win_i || !bus.imem_valid) ? '0 :
               scnt_q == sw'(starve_limit) ? scnt_q : scnt_q + sw'(1);
    instr_d  = load ? win_i : instr_q;
    addr_d   = load ? (win_i ? bus.imem_addr & ~32'd3 : bus.dmem_addr) : addr_q;
    wdata_d  = load ? (win_i ? 32'd0 : bus.dmem_wdata) : wdata_q;
    wstrb_d  = load ? (win_i ? 4'd0 : bus.dmem_wstrb) : wstrb_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= idle;
      scnt_q  <= '0;
      instr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end
  assign bus.mem_valid  = busy;
  assign bus.mem_instr  = busy && instr_q;
  assign bus.mem_addr   = busy ? addr_q : 32'd0;
  assign bus.mem_wdata  = busy ? wdata_q : 32'd0;
  assign bus.mem_wstrb  = busy ? wstrb_q : 4'd0;
  assign bus.imem_ready = state_q == gnt_i && bus.mem_ready;
  assign bus.dmem_ready = state_q == gnt_d && bus.mem_ready;
  assign bus.imem_rdata = bus.imem_ready ? bus.mem_rdata : 32'd0;
  assign bus.dmem_rdata = bus.dmem_ready ? bus.mem_rdata : 32'd0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int lim = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int dstreak = 0;
  mem_arbiter_if bus ();
  mem_arbiter #(.starve_limit(lim)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_mem_valid"}, 32'(bus.mem_valid), 0);
    chk({tag, "_mem_instr"}, 32'(bus.mem_instr), 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_mem_wstrb"}, 32'(bus.mem_wstrb), 0);
    chk({tag, "_imem_ready"}, 32'(bus.imem_ready), 0);
    chk({tag, "_imem_rdata"}, bus.imem_rdata, 0);
    chk({tag, "_dmem_ready"}, 32'(bus.dmem_ready), 0);
    chk({tag, "_dmem_rdata"}, bus.dmem_rdata, 0);
  endtask
  // Entered at a falling edge in IDLE with requests already set; leaves at the falling edge of the next IDLE.
  task automatic txn(input int waits, input logic [31:0] rd, input bit keep, input bit scramble, output logic obs_i);
    logic wi;
    logic [31:0] ea, ew;
    logic [3:0] es;
    wi = bus.imem_valid && (!bus.dmem_valid || dstreak == lim);
    ea = wi ? {bus.imem_addr[31:2], 2'b00} : bus.dmem_addr;
    ew = wi ? 32'd0 : bus.dmem_wdata;
    es = wi ? 4'd0 : bus.dmem_wstrb;
    dstreak = (wi || !bus.imem_valid) ? 0 : (dstreak < lim ? dstreak + 1 : lim);
    @(posedge clk);
    @(negedge clk);
    #1 obs_i = bus.mem_instr;
    for (int k = 0; k <= waits; k++) begin
      if (scramble && !wi && k < waits) begin
        bus.dmem_addr = $urandom;
        bus.dmem_wdata = $urandom;
      end
      if (k == waits) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rd;
      end
      #1;
      chk("mem_valid", 32'(bus.mem_valid), 1);
      chk("mem_instr", 32'(bus.mem_instr), 32'(wi));
      chk("mem_addr", bus.mem_addr, ea);
      chk("mem_wdata", bus.mem_wdata, ew);
      chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(es));
      chk("imem_ready", 32'(bus.imem_ready), 32'(k == waits && wi));
      chk("imem_rdata", bus.imem_rdata, (k == waits && wi) ? rd : 32'd0);
      chk("dmem_ready", 32'(bus.dmem_ready), 32'(k == waits && !wi));
      chk("dmem_rdata", bus.dmem_rdata, (k == waits && !wi) ? rd : 32'd0);
      if (k < waits) @(negedge clk);
    end
    @(negedge clk);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = $urandom;
    if (!keep && wi) bus.imem_valid = 1'b0;
    if (!keep && !wi) bus.dmem_valid = 1'b0;
    if (keep && wi) bus.imem_addr = $urandom;
    if (keep && !wi) begin
      bus.dmem_addr = $urandom;
      bus.dmem_wdata = $urandom;
    end
    #1 chk_zero("done");
    @(negedge clk);
    #1 chk_zero("idle");
  endtask
  initial begin
    logic obs_i;
    logic [9:0] pat;
    bus.imem_valid = 1'b0;
    bus.imem_addr = '0;
    bus.dmem_valid = 1'b0;
    bus.dmem_addr = '0;
    bus.dmem_wdata = '0;
    bus.dmem_wstrb = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_zero("reset");
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 chk_zero("post_reset");
    end
    bus.imem_valid = 1'b1;
    bus.imem_addr = 32'h0000_1006;
    txn(2, 32'hDEAD_BEEF, 1'b0, 1'b0, obs_i);
    chk("fetch_instr", 32'(obs_i), 1);
    bus.dmem_valid = 1'b1;
    bus.dmem_addr = 32'h0000_2000;
    bus.dmem_wdata = 32'h1234_5678;
    bus.dmem_wstrb = 4'b0011;
    txn(0, 32'h0BAD_F00D, 1'b1, 1'b0, obs_i);
    chk("store_instr", 32'(obs_i), 0);
    txn(0, 32'h0000_0001, 1'b0, 1'b0, obs_i);
    bus.dmem_valid = 1'b1;
    bus.dmem_wstrb = 4'b0000;
    bus.imem_valid = 1'b1;
    txn(1, $urandom, 1'b0, 1'b0, obs_i);
    chk("collision_first", 32'(obs_i), 0);
    txn(0, $urandom, 1'b0, 1'b0, obs_i);
    chk("collision_second", 32'(obs_i), 1);
    pat = 10'b10_0001_0000;
    bus.imem_valid = 1'b1;
    bus.dmem_valid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      txn($urandom_range(0, 2), $urandom, 1'b1, 1'b0, obs_i);
      chk("starve_order", 32'(obs_i), 32'(pat[t]));
      if (pat[t]) chk("scnt_clear", 32'(dut.scnt_q), 0);
    end
    bus.imem_valid = 1'b0;
    bus.dmem_valid = 1'b0;
    repeat (2) @(negedge clk);
    dstreak = 0;
    bus.dmem_valid = 1'b1;
    bus.dmem_addr = 32'h0000_3000;
    bus.dmem_wdata = 32'hCAFE_0001;
    bus.dmem_wstrb = 4'b1111;
    txn(5, 32'h5555_AAAA, 1'b0, 1'b1, obs_i);
    bus.mem_ready = 1'b1;
    #1 chk("spurious_imem_ready", 32'(bus.imem_ready), 0);
    chk("spurious_dmem_ready", 32'(bus.dmem_ready), 0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1 chk_zero("spurious_after");
    bus.dmem_valid = 1'b1;
    bus.dmem_addr = 32'h0000_4000;
    @(posedge clk);
    @(negedge clk);
    #1 chk("pre_reset_valid", 32'(bus.mem_valid), 1);
    #1 rst = 1'b1;
    #1 chk_zero("reset_mid");
    @(negedge clk);
    bus.dmem_valid = 1'b0;
    rst = 1'b0;
    dstreak = 0;
    repeat (2) @(negedge clk);
    #1 chk_zero("reset_mid_after");
    for (int t = 0; t < 60; t++) begin
      if (!bus.imem_valid && $urandom_range(0, 1) == 1) begin
        bus.imem_valid = 1'b1;
        bus.imem_addr = $urandom;
      end
      if (!bus.dmem_valid && $urandom_range(0, 1) == 1) begin
        bus.dmem_valid = 1'b1;
        bus.dmem_addr = $urandom;
        bus.dmem_wdata = $urandom;
        bus.dmem_wstrb = 4'($urandom);
      end
      if (!bus.imem_valid && !bus.dmem_valid) begin
        bus.imem_valid = 1'b1;
        bus.imem_addr = $urandom;
      end
      txn($urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)), 1'b0, obs_i);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
